// File: rtl/mux_scan_seq_if.sv
// mux_scan_seq_if: source bank and sample bus of mux_scan_seq.
// master drives en/mode/sel_in/din (+skip_mask with MUX_SKIP_MASK_EN),
// slave returns dout/sel_out/valid/wrap/sel_err.
interface mux_scan_seq_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
);
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel_in;
  logic [CHANNELS*WIDTH-1:0] din;
`ifdef MUX_SKIP_MASK_EN
  logic [CHANNELS-1:0]       skip_mask;
`endif
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          sel_out;
  logic                      valid;
  logic                      wrap;
  logic                      sel_err;

  modport master (
`ifdef MUX_SKIP_MASK_EN
    output skip_mask,
`endif
    output en, mode, sel_in, din,
    input  dout, sel_out, valid, wrap, sel_err
  );

  modport slave (
`ifdef MUX_SKIP_MASK_EN
    input  skip_mask,
`endif
    input  en, mode, sel_in, din,
    output dout, sel_out, valid, wrap, sel_err
  );
endinterface

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered N:1 mux with manual select and auto scan.
// Ports: clk, rst_n (async, active-low), bus (mux_scan_seq_if.slave).
// Optional MUX_SKIP_MASK_EN: scan skips channels with skip_mask[k]=1.
module mux_scan_seq #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 1
) (
  input logic           clk,
  input logic           rst_n,
  mux_scan_seq_if.slave bus
);
  localparam int DC_W = $clog2(DWELL) + 1;
  localparam logic [DC_W-1:0] DC_LAST =
    DC_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0] ch, ch_nxt;
  logic [DC_W-1:0]  dc, dc_nxt, dc_cur;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic             valid_q, valid_nxt;
  logic             wrap_q, wrap_nxt;
  logic             err_q, err_nxt;

  logic [SEL_W-1:0] first;
  logic [SEL_W-1:0] cur;
  logic [SEL_W-1:0] adv;
  logic             last;
  logic             any_on;

  function automatic logic [WIDTH-1:0] slice(
    input logic [CHANNELS*WIDTH-1:0] d,
    input logic [SEL_W-1:0]          idx
  );
    slice = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (SEL_W'(k) == idx)
        slice = d[k*WIDTH +: WIDTH];
  endfunction

  // cur: channel sampled this edge (scan entry restarts
  // at the first scannable channel); adv: its successor.
`ifdef MUX_SKIP_MASK_EN
  logic up_ok;

  always_comb begin
    first  = '0;
    any_on = 1'b0;
    adv    = '0;
    up_ok  = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (!bus.skip_mask[k]) begin
        first  = SEL_W'(k);
        any_on = 1'b1;
      end
    cur = (state == SCAN) ? ch : first;
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (!bus.skip_mask[k] &&
          SEL_W'(k) > cur) begin
        adv   = SEL_W'(k);
        up_ok = 1'b1;
      end
    // nothing unmasked above cur: sweep ends here
    last = !up_ok;
    if (!up_ok)
      adv = first;
  end
`else
  localparam logic [SEL_W-1:0] CH_LAST =
    SEL_W'(CHANNELS - 1);

  always_comb begin
    first  = '0;
    any_on = 1'b1;
    cur    = (state == SCAN) ? ch : first;
    last   = (cur == CH_LAST);
    adv    = last ? '0 : cur + 1'b1;
  end
`endif

  assign dc_cur = (state == SCAN) ? dc : '0;

  always_comb begin
    state_nxt = IDLE;
    ch_nxt    = '0;
    dc_nxt    = '0;
    dout_nxt  = dout_q;
    sel_nxt   = sel_q;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (1'b1)
      !bus.en: begin
        state_nxt = IDLE;
      end
      bus.en && !bus.mode: begin
        state_nxt = MANUAL;
        sel_nxt   = bus.sel_in;
        if (int'(bus.sel_in) < CHANNELS) begin
          dout_nxt  = slice(bus.din, bus.sel_in);
          valid_nxt = 1'b1;
        end else begin
          dout_nxt = '0;
          err_nxt  = 1'b1;
        end
      end
      bus.en && bus.mode: begin
        state_nxt = SCAN;
        dout_nxt  = slice(bus.din, cur);
        sel_nxt   = cur;
        ch_nxt    = cur;
        if (!any_on) begin
          dc_nxt = '0;
        end else if (dc_cur == DC_LAST) begin
          valid_nxt = 1'b1;
          wrap_nxt  = last;
          ch_nxt    = adv;
        end else begin
          dc_nxt = dc_cur + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= '0;
      dc      <= '0;
      dout_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      dc      <= dc_nxt;
      dout_q  <= dout_nxt;
      sel_q   <= sel_nxt;
      valid_q <= valid_nxt;
      wrap_q  <= wrap_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.sel_out = sel_q;
  assign bus.valid   = valid_q;
  assign bus.wrap    = wrap_q;
  assign bus.sel_err = err_q;
endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: directed bench for mux_scan_seq.
// Four parameterisations driven from shared stimulus.
module tb_mux_scan_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en, mode;
  logic [2:0]  sel_in;
  logic [7:0]  din8;
  logic [7:0]  mask;
  logic [1:0]  sel2;
  logic [11:0] din12;

  int checks = 0;
  int failures = 0;

  mux_scan_seq_if #(.WIDTH(1), .CHANNELS(8), .SEL_W(3)) m8_if ();
  mux_scan_seq_if #(.WIDTH(1), .CHANNELS(6), .SEL_W(3)) m6_if ();
  mux_scan_seq_if #(.WIDTH(1), .CHANNELS(8), .SEL_W(3)) s8_if ();
  mux_scan_seq_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) w4_if ();

  assign m8_if.en = en;
  assign m8_if.mode = mode;
  assign m8_if.sel_in = sel_in;
  assign m8_if.din = din8;
  assign m6_if.en = en;
  assign m6_if.mode = mode;
  assign m6_if.sel_in = sel_in;
  assign m6_if.din = din8[5:0];
  assign s8_if.en = en;
  assign s8_if.mode = mode;
  assign s8_if.sel_in = sel_in;
  assign s8_if.din = din8;
  assign w4_if.en = en;
  assign w4_if.mode = mode;
  assign w4_if.sel_in = sel2;
  assign w4_if.din = din12;
`ifdef MUX_SKIP_MASK_EN
  assign m8_if.skip_mask = mask;
  assign m6_if.skip_mask = mask[5:0];
  assign s8_if.skip_mask = mask;
  assign w4_if.skip_mask = mask[2:0];
`endif

  mux_scan_seq #(.WIDTH(1), .CHANNELS(8), .SEL_W(3), .DWELL(1))
    u_m8 (.clk(clk), .rst_n(rst_n), .bus(m8_if.slave));
  mux_scan_seq #(.WIDTH(1), .CHANNELS(6), .SEL_W(3), .DWELL(1))
    u_m6 (.clk(clk), .rst_n(rst_n), .bus(m6_if.slave));
  mux_scan_seq #(.WIDTH(1), .CHANNELS(8), .SEL_W(3), .DWELL(3))
    u_s8 (.clk(clk), .rst_n(rst_n), .bus(s8_if.slave));
  mux_scan_seq #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(2))
    u_w4 (.clk(clk), .rst_n(rst_n), .bus(w4_if.slave));

  typedef struct {
    logic [1:0]  sel;
    logic [11:0] din;
    logic [3:0]  d;
    logic        v;
    logic        e;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [31:0] pk(
    input logic [3:0] d, input logic [2:0] s,
    input logic v, input logic w, input logic e);
    return {23'd0, d, s, v, w, e};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] o_m8();
    return pk(4'(m8_if.dout), m8_if.sel_out,
              m8_if.valid, m8_if.wrap, m8_if.sel_err);
  endfunction
  function automatic logic [31:0] o_m6();
    return pk(4'(m6_if.dout), m6_if.sel_out,
              m6_if.valid, m6_if.wrap, m6_if.sel_err);
  endfunction
  function automatic logic [31:0] o_s8();
    return pk(4'(s8_if.dout), s8_if.sel_out,
              s8_if.valid, s8_if.wrap, s8_if.sel_err);
  endfunction
  function automatic logic [31:0] o_w4();
    return pk(w4_if.dout, 3'(w4_if.sel_out),
              w4_if.valid, w4_if.wrap, w4_if.sel_err);
  endfunction

  // c = cycles since scan entry, mask clear
  task automatic chk_scan(input int c);
    int k;
    logic v;
    k = (c / 3) % 8;
    v = (c % 3 == 2);
    chk("scan_s8", o_s8(),
        pk(4'(din8[k]), 3'(k), v, v && k == 7, 1'b0));
    k = c % 8;
    chk("scan_m8", o_m8(),
        pk(4'(din8[k]), 3'(k), 1'b1, k == 7, 1'b0));
    k = c % 6;
    chk("scan_m6", o_m6(),
        pk(4'(din8[k]), 3'(k), 1'b1, k == 5, 1'b0));
    k = (c / 2) % 3;
    v = (c % 2 == 1);
    chk("scan_w4", o_w4(),
        pk(din12[k*4 +: 4], 3'(k), v, v && k == 2, 1'b0));
  endtask

  initial begin
    int sq[4];
    sq = '{0, 3, 4, 6};
    tbl[0] = '{2'd0, 12'h3A5, 4'h5, 1'b1, 1'b0};
    tbl[1] = '{2'd1, 12'h3A5, 4'hA, 1'b1, 1'b0};
    tbl[2] = '{2'd2, 12'h3A5, 4'h3, 1'b1, 1'b0};
    tbl[3] = '{2'd3, 12'h3A5, 4'h0, 1'b0, 1'b1};
    tbl[4] = '{2'd2, 12'hF00, 4'hF, 1'b1, 1'b0};
    tbl[5] = '{2'd1, 12'h0C0, 4'hC, 1'b1, 1'b0};
    tbl[6] = '{2'd3, 12'hFFF, 4'h0, 1'b0, 1'b1};
    tbl[7] = '{2'd0, 12'h00E, 4'hE, 1'b1, 1'b0};

    rst_n = 1'b0;
    en = 1'b0;
    mode = 1'b0;
    sel_in = '0;
    din8 = '0;
    mask = '0;
    sel2 = '0;
    din12 = '0;

    // reset state
    step();
    step();
    chk("rst_m8", o_m8(), 32'd0);
    chk("rst_m6", o_m6(), 32'd0);
    chk("rst_s8", o_s8(), 32'd0);
    chk("rst_w4", o_w4(), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_s8", o_s8(), 32'd0);

    // manual table, WIDTH=4 CHANNELS=3
    en = 1'b1;
    mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel2 = tbl[i].sel;
      din12 = tbl[i].din;
      step();
      chk("tbl_w4", o_w4(),
          pk(tbl[i].d, 3'(tbl[i].sel),
             tbl[i].v, 1'b0, tbl[i].e));
    end

    // exhaustive manual, 8 and 6 channels
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] v;
      v = 11'(i);
      sel_in = v[10:8];
      din8 = v[7:0];
      step();
      chk("man_m8", o_m8(),
          pk(4'(din8[sel_in]), sel_in, 1'b1, 1'b0, 1'b0));
      if (sel_in < 3'd6)
        chk("man_m6", o_m6(),
            pk(4'(din8[sel_in]), sel_in, 1'b1, 1'b0, 1'b0));
      else
        chk("oor_m6", o_m6(),
            pk(4'd0, sel_in, 1'b0, 1'b0, 1'b1));
    end

    // full scan sweeps from idle
    en = 1'b0;
    step();
    chk("idle_flags",
        32'({s8_if.valid, s8_if.wrap, s8_if.sel_err}), 32'd0);
    din8 = 8'hA5;
    din12 = 12'h3A5;
    en = 1'b1;
    mode = 1'b1;
    for (int c = 0; c < 48; c++) begin
      step();
      chk_scan(c);
    end

    // mid-sweep mode change and enable drop
    sel_in = 3'd6;
    mode = 1'b0;
    step();
    chk("man_s8", o_s8(), pk(4'd0, 3'd6, 1'b1, 1'b0, 1'b0));
    mode = 1'b1;
    for (int c = 0; c < 13; c++) begin
      step();
      chk_scan(c);
    end
    mode = 1'b0;
    step();
    chk("abort_s8", o_s8(), pk(4'd0, 3'd6, 1'b1, 1'b0, 1'b0));
    mode = 1'b1;
    for (int c = 0; c < 24; c++) begin
      step();
      chk_scan(c);
    end
    en = 1'b0;
    step();
    chk("en_off_s8", o_s8(), pk(4'd1, 3'd7, 1'b0, 1'b0, 1'b0));
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk_scan(c);
    end

`ifdef MUX_SKIP_MASK_EN
    en = 1'b0;
    step();
    mask = 8'b1010_0110;
    en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      int k;
      k = sq[c % 4];
      step();
      chk("skip_m8", o_m8(),
          pk(4'(din8[k]), 3'(k), 1'b1, k == 6, 1'b0));
    end
    mask = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("allmask_m8",
          32'({m8_if.valid, m8_if.wrap}), 32'd0);
    end
    mask = 8'h00;
`endif

    // async reset in the middle of a scan
    en = 1'b0;
    step();
    en = 1'b1;
    mode = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_scan(c);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s8", o_s8(), 32'd0);
    chk("arst_m8", o_m8(), 32'd0);
    en = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_s8", o_s8(), 32'd0);
    chk("post_rst_w4", o_w4(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
